out_buf_sched: RTL



---
 rtl/out_buf_sched_if.sv | 30 +++
 rtl/out_buf_sched.sv | 96 +++++++++
 2 files changed

// File: rtl/out_buf_sched_if.sv
// Handshake bundle between the accumulator stage, the output buffer scheduler
// and the downstream output register.
interface out_buf_sched_if #(
    parameter int N     = 8,
    parameter int DEPTH = 8
) ();
    localparam int CW = $clog2(DEPTH + 1);

    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_data;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_data;
    logic          out_last;
    logic          s;
    logic          busy;
    logic [CW-1:0] count;

    modport master (
        output in_valid, in_data, flush, out_ready,
        input  in_ready, out_valid, out_data, out_last, s, busy, count
    );

    modport slave (
        input  in_valid, in_data, flush, out_ready,
        output in_ready, out_valid, out_data, out_last, s, busy, count
    );
endinterface

// File: rtl/out_buf_sched.sv
// Batch output buffer: fills up to DEPTH words, then drains them in order with
// a valid/ready handshake and a per-word shift strobe for the output register.
module out_buf_sched #(
    parameter int N     = 8,
    parameter int DEPTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    out_buf_sched_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t        state_reg;
    logic [CW-1:0] wr_ptr_reg;
    logic [CW-1:0] rd_ptr_reg;
    logic [CW-1:0] len_reg;
    logic [N-1:0]  mem [DEPTH];

    logic          in_ready;
    logic          out_valid;
    logic          out_last;
    logic          in_acc;
    logic          out_acc;
    logic [CW-1:0] wr_ptr_next;

    // Handshake flags come from registered state only; s is the lone combinational output.
    assign in_ready    = (state_reg != DRAIN);
    assign out_valid   = (state_reg == DRAIN);
    assign out_last    = out_valid && (rd_ptr_reg == len_reg - CW'(1));
    assign in_acc      = bus.in_valid && in_ready;
    assign out_acc     = out_valid && bus.out_ready;
    assign wr_ptr_next = wr_ptr_reg + CW'(in_acc);

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_last  = out_last;
    assign bus.out_data  = mem[rd_ptr_reg[AW-1:0]];
    assign bus.s         = out_acc;
    assign bus.busy      = (state_reg != IDLE);
    assign bus.count     = (state_reg == DRAIN) ? (len_reg - rd_ptr_reg) : wr_ptr_reg;

    // wr_ptr is cleared on every return to IDLE, so it addresses buf[0] there too.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (in_acc && wr_ptr_reg == CW'(gi)) begin
                mem[gi] <= bus.in_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            len_reg    <= '0;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (in_acc) begin
                        wr_ptr_reg <= CW'(1);
                        state_reg  <= FILL;
                    end
                end
                FILL: begin
                    wr_ptr_reg <= wr_ptr_next;
                    if (wr_ptr_next == CW'(DEPTH) || bus.flush) begin
                        len_reg    <= wr_ptr_next;
                        rd_ptr_reg <= '0;
                        state_reg  <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (out_acc) begin
                        if (out_last) begin
                            wr_ptr_reg <= '0;
                            rd_ptr_reg <= '0;
                            len_reg    <= '0;
                            state_reg  <= IDLE;
                        end else begin
                            rd_ptr_reg <= rd_ptr_reg + CW'(1);
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule
